// File: rtl/dreg_alu_sequencer_pkg.sv
// dreg_alu_sequencer_pkg: shared encodings for the sliced register ALU sequencer
package dreg_alu_sequencer_pkg;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_EOR, OP_MOVE, OP_ADDX, OP_CMP
  } op_e;
  typedef enum logic [1:0] {SZ_BYTE, SZ_WORD, SZ_LONG, SZ_ILL} size_e;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LO, S_HI, S_DONE} state_e;
  localparam int CCR_C = 0;
  localparam int CCR_V = 1;
  localparam int CCR_Z = 2;
  localparam int CCR_N = 3;
  localparam int CCR_X = 4;
endpackage

// File: rtl/dreg_alu_sequencer_alu_slice.sv
// alu_slice: one W-bit ALU step; narrow moves carry/overflow taps to bit W/2-1
module alu_slice
  import dreg_alu_sequencer_pkg::*;
#(
  parameter int W = 16
) (
  input  op_e          op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         narrow,
  output logic [W-1:0] res,
  output logic         cout,
  output logic         ovf
);
  localparam int H = W / 2;
  logic         sub, arith, ci, am, bm, rm, c_full, c_half;
  logic [W-1:0] bb;
  logic [W:0]   sum;
  always_comb begin
    sub    = op inside {OP_SUB, OP_CMP};
    arith  = sub || op inside {OP_ADD, OP_ADDX};
    bb     = sub ? ~b : b;
    ci     = sub ? ~cin : cin;
    sum    = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, ci};
    // carry out of bit H-1 recovered from the sum bit at H
    c_half = sum[H] ^ a[H] ^ bb[H];
    c_full = narrow ? c_half : sum[W];
    am     = narrow ? a[H-1] : a[W-1];
    bm     = narrow ? bb[H-1] : bb[W-1];
    rm     = narrow ? sum[H-1] : sum[W-1];
    res    = op == OP_AND  ? a & b :
             op == OP_OR   ? a | b :
             op == OP_EOR  ? a ^ b :
             op == OP_MOVE ? b : sum[W-1:0];
    cout   = arith & (sub ^ c_full);
    ovf    = arith & (am == bm) & (rm != am);
  end
endmodule

// File: rtl/dreg_alu_sequencer.sv
// dreg_alu_sequencer: register file plus two-slice ALU sequencer with sized writeback and CCR
module dreg_alu_sequencer
  import dreg_alu_sequencer_pkg::*;
#(
  parameter int NREGS   = 8,
  parameter int REG_W   = 32,
  parameter int SLICE_W = 16,
  localparam int SW     = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [1:0]       size,
  input  logic [SW-1:0]    src,
  input  logic [SW-1:0]    dst,
  input  logic             ld_en,
  input  logic [SW-1:0]    ld_sel,
  input  logic [REG_W-1:0] ld_data,
  input  logic [SW-1:0]    rd_sel,
  output logic [REG_W-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [4:0]       ccr
);
  localparam int H = SLICE_W / 2;
  state_e             state, nxt;
  op_e                op_q;
  size_e              size_q;
  logic [SW-1:0]      src_q, dst_q;
  logic [REG_W-1:0]   opa, opb, cur, wb_val;
  logic [SLICE_W-1:0] lo_q, alu_a, alu_b, alu_r;
  logic               c_lo, err_q, alu_cin, alu_c, alu_v, narrow, hi, fin, wb_en, ld_ok;
  logic               idle_like, res_z, res_n, arith;
  logic [4:0]         ccr_q, ccr_nx;
  logic [REG_W-1:0]   rf [NREGS];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= nxt;
  always_comb begin
    idle_like = state == S_IDLE || state == S_DONE;
    nxt = idle_like ? (start ? (size == SZ_ILL ? S_DONE : S_FETCH) : S_IDLE) :
          state == S_FETCH ? S_LO :
          state == S_LO && size_q == SZ_LONG ? S_HI : S_DONE;
  end
  assign busy    = state inside {S_FETCH, S_LO, S_HI};
  assign done    = state == S_DONE;
  assign err     = done & err_q;
  assign ccr     = ccr_q;
  assign rd_data = rf[rd_sel];
  always_comb begin
    hi      = state == S_HI;
    narrow  = !hi && size_q == SZ_BYTE;
    alu_a   = hi ? opa[REG_W-1:SLICE_W] : opa[SLICE_W-1:0];
    alu_b   = hi ? opb[REG_W-1:SLICE_W] : opb[SLICE_W-1:0];
    alu_cin = hi ? c_lo : (op_q == OP_ADDX) & ccr_q[CCR_X];
    fin     = (state == S_LO && size_q != SZ_LONG) || hi;
    arith   = op_q inside {OP_ADD, OP_SUB, OP_ADDX, OP_CMP};
    cur     = rf[dst_q];
    wb_val  = hi ? {alu_r, lo_q} :
              size_q == SZ_BYTE ? {cur[REG_W-1:H], alu_r[H-1:0]} :
              {cur[REG_W-1:SLICE_W], alu_r};
    res_z   = hi ? {alu_r, lo_q} == '0 : narrow ? alu_r[H-1:0] == '0 : alu_r == '0;
    res_n   = narrow ? alu_r[H-1] : alu_r[SLICE_W-1];
    ccr_nx  = ccr_q;
    ccr_nx[CCR_X] = arith && op_q != OP_CMP ? alu_c : ccr_q[CCR_X];
    ccr_nx[CCR_N] = res_n;
    // ADDX lets Z accumulate across multi-precision chains
    ccr_nx[CCR_Z] = op_q == OP_ADDX ? res_z & ccr_q[CCR_Z] : res_z;
    ccr_nx[CCR_V] = alu_v;
    ccr_nx[CCR_C] = alu_c;
    wb_en   = fin && op_q != OP_CMP;
    ld_ok   = ld_en && !busy;
  end
  alu_slice #(.W(SLICE_W)) u_alu (
    .op(op_q), .a(alu_a), .b(alu_b), .cin(alu_cin), .narrow(narrow),
    .res(alu_r), .cout(alu_c), .ovf(alu_v)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_q   <= OP_ADD;
      size_q <= SZ_BYTE;
      src_q  <= '0;
      dst_q  <= '0;
      opa    <= '0;
      opb    <= '0;
      lo_q   <= '0;
      c_lo   <= 1'b0;
      err_q  <= 1'b0;
      ccr_q  <= '0;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      if (idle_like && start && size != SZ_ILL) begin
        op_q   <= op_e'(op);
        size_q <= size_e'(size);
        src_q  <= src;
        dst_q  <= dst;
      end
      if (state == S_FETCH) begin
        opa <= rf[dst_q];
        opb <= rf[src_q];
      end
      if (state == S_LO) begin
        lo_q <= alu_r;
        c_lo <= alu_c;
      end
      if (fin) ccr_q <= ccr_nx;
      err_q <= idle_like && start && size == SZ_ILL;
      if (ld_ok) rf[ld_sel] <= ld_data;
      else if (wb_en) rf[dst_q] <= wb_val;
    end
endmodule

// File: doc/dreg_alu_sequencer.md
DREG_ALU_SEQUENCER -- requirements
Module: dreg_alu_sequencer

Interface
REQ-001 Parameter NREGS, 8, number of data registers; register select width is clog2(NREGS).
REQ-002 Parameter REG_W, 32, register width; SHALL equal 2*SLICE_W.
REQ-003 Parameter SLICE_W, 16, ALU slice width processed per cycle.
REQ-004 CLK  in  1  sole clock; all state updates on rising edge.
REQ-005 RESET_N  in  1  reset, asynchronous, active-low.
REQ-006 START  in  1  request; sampled only in IDLE or DONE state.
REQ-007 OP  in  3  0 ADD, 1 SUB (dst-src), 2 AND, 3 OR, 4 EOR, 5 MOVE (dst=src), 6 ADDX (dst+src+X), 7 CMP (dst-src, no writeback).
REQ-008 SIZE  in  2  0 byte (8), 1 word (16), 2 long (32), 3 illegal.
REQ-009 SRC, DST  in  clog2(NREGS) each  operand register selects.
REQ-010 LD_EN, LD_SEL, LD_DATA  in  1/clog2(NREGS)/REG_W  direct full-width register load.
REQ-011 RD_SEL in clog2(NREGS); RD_DATA out REG_W  combinational register read.
REQ-012 BUSY out 1; DONE out 1; ERR out 1; CCR out 5 as {X,N,Z,V,C}.

Function
REQ-013 States: IDLE, FETCH, SLICE_LO, SLICE_HI, DONE; DONE lasts exactly one cycle.
REQ-014 IDLE/DONE + START with legal SIZE -> FETCH, latching OP, SIZE, SRC, DST; else DONE -> IDLE.
REQ-015 FETCH latches both full operands -> SLICE_LO.
REQ-016 SLICE_LO computes bits [SLICE_W-1:0] with carry-in 0 (X for ADDX, borrow form for SUB/CMP); byte/word -> DONE, long -> SLICE_HI.
REQ-017 SLICE_HI computes upper slice with carry-in = SLICE_LO carry-out -> DONE.
REQ-018 Writeback to DST and CCR update occur on the edge entering DONE; DONE=1 in that cycle.
REQ-019 Latency START-sample edge to DONE high: 3 cycles byte/word, 4 cycles long.
REQ-020 Writeback replaces only the low 8/16/32 bits of DST; upper bits preserved.
REQ-021 Byte ops take carry/overflow from bit 7, word from bit 15, long from bit 31.
REQ-022 N = MSB of sized result; Z = sized result all zero, except ADDX clears Z only if result nonzero, else Z unchanged.
REQ-023 ADD/SUB/ADDX/CMP: V = signed overflow, C = carry/borrow; X = C for ADD/SUB/ADDX, X unchanged for CMP.
REQ-024 AND/OR/EOR/MOVE: V=0, C=0, X unchanged.
REQ-025 CMP never writes a register.
REQ-026 BUSY=1 in FETCH, SLICE_LO, SLICE_HI only; START while BUSY is ignored, not queued.
REQ-027 START in DONE state is accepted (back-to-back operation).
REQ-028 LD_EN honoured only when BUSY=0; if DONE writeback and LD_EN target same register in the same cycle, LD_EN wins.
REQ-029 SRC==DST legal; operands taken from FETCH snapshot.
REQ-030 SIZE=3 on START: no register/CCR change, go to DONE next edge with DONE=1 and ERR=1; ERR=0 at all other times.

Reset
REQ-031 RESET_N low: state IDLE, all registers 0, CCR 0, BUSY/DONE/ERR 0, immediately and asynchronously.
REQ-032 Reset mid-operation aborts with no writeback; START must be reissued after release.

Structure
REQ-033 Shared package holds OP and SIZE encodings, state enum, CCR bit indices.
REQ-034 One sub-module alu_slice: SLICE_W-bit combinational op with carry-in, carry-out, overflow, result.
REQ-035 Register file is internal; single write port shared by writeback and LD port.

Verification
REQ-036 D0=0x0000FFFF, D1=1, ADD.L src=D1 dst=D0 -> DONE 4 cycles after START, D0=0x00010000, CCR X=0 N=0 Z=0 V=0 C=0.
REQ-037 D0=0x1234FFFF, D1=1, ADD.W -> DONE after 3 cycles, D0=0x12340000, X=1 Z=1 C=1 N=0 V=0.
REQ-038 D2=0xAAAAAA80, D3=1, SUB.B src=D3 dst=D2 -> D2=0xAAAAAA7F, V=1 N=0 C=0 Z=0.
REQ-039 D4=5, D5=5, CMP.L -> Z=1 C=0, D4 unchanged, X unchanged; START pulse while BUSY -> no second DONE.
REQ-040 Reset asserted during SLICE_HI of ADD.L -> all outputs 0, D-registers 0, no DONE; SIZE=3 START -> DONE+ERR one cycle, CCR unchanged.
